rgb_pwm_driver: RTL and testbench
=================================

Name: rgb_pwm_driver

Overview:
- Downstream consumer of the 24-bit light word (R[23:16], G[15:8], B[7:0]) produced by the light selector.
- Converts the word into three 8-bit-resolution PWM LED drive pins.
- Optional per-period fade ramps each channel's duty toward the requested colour, so button and sel changes do not step abruptly.
- Duty updates happen only at PWM period boundaries, so output waveforms never glitch mid-period.

Parameters:
- PRESCALE, 4, clk cycles per PWM tick; legal range 1..65535.
- FADE_PERIODS, 0, PWM periods between fade steps of ±1. 0 means the duty jumps to the target at each boundary. Legal range 0..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = run PWM; 0 = outputs forced low and counters cleared
- light  input  24  requested colour, R[23:16] G[15:8] B[7:0]
- led_r  output  1  red PWM drive, registered
- led_g  output  1  green PWM drive, registered
- led_b  output  1  blue PWM drive, registered
- frame  output  1  one-clk pulse marking the start of each PWM period
- busy  output  1  high while any duty differs from the latched target

Behaviour:
- Reset (rst=1 at a clk edge): all internal state and all outputs go to 0 on that edge.
  - Internal state: pre_cnt, pwm_cnt, fade_cnt, duty_r/g/b, target.
  - Outputs: led_r/g/b, frame, busy.
  - Reset has priority over enable and over any in-progress fade.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 while enable=1.
  - tick = enable & (pre_cnt == PRESCALE-1).
  - PRESCALE=1 gives tick on every enabled cycle.
- PWM counter:
  - pwm_cnt (8 bits) increments on tick and counts 0..254.
  - wrap = tick & (pwm_cnt == 254); on wrap, pwm_cnt goes to 0.
  - Period = 255 ticks = 255*PRESCALE clk cycles.
- Boundary event (on the wrap cycle):
  - target is loaded with light as sampled on that cycle.
  - If FADE_PERIODS=0: duty_x is loaded with light's channel x.
  - Else: fade_cnt increments. When it reaches FADE_PERIODS-1, it clears and each duty_x moves by 1 toward light's channel x (unchanged if equal). Otherwise duty is held.
  - No overflow or underflow is possible: duty never passes its target.
- light changes between boundaries have no effect until the next wrap.
- Outputs:
  - led_x <= enable & (pwm_cnt < duty_x): one-clk latency from counter to pin.
  - duty 0 gives a constant low; duty 255 gives a constant high (pwm_cnt max is 254). High time = duty_x*PRESCALE clk cycles per period.
- frame <= wrap: high for exactly the one clk after each wrap, i.e. the first cycle with pwm_cnt = 0 of the new period.
- busy: (duty_r != target[23:16]) | (duty_g != target[15:8]) | (duty_b != target[7:0]), derived from registers only. It is always 0 when FADE_PERIODS=0 and fully settled.
- After reset, duty=0, so LEDs stay dark for the whole first period; the first light sample is taken at the first wrap.
- enable=0:
  - On the next edge, pre_cnt, pwm_cnt and fade_cnt clear to 0.
  - led_r/g/b and frame go to 0.
  - duty and target hold.
  - On re-enable, counting restarts from pwm_cnt=0 with no frame pulse until the next wrap.
- Simultaneous events:
  - rst beats enable.
  - A wrap coinciding with a light change samples the new light value present on that cycle.

Test Plan:
1. PRESCALE=1, FADE_PERIODS=0; reset, enable=1, light=24'hFF0000.
   - Required: leds low for cycles 0..255.
   - After the first wrap, led_r constant 1 and led_g/led_b constant 0.
   - frame pulses every 255 cycles.
2. PRESCALE=2, FADE_PERIODS=0, light=24'h804000; measure the second full period (510 clk).
   - Required: led_r high 256 clk, led_g high 128 clk, led_b high 0 clk.
   - Highs are contiguous from the frame-aligned start, after the 1-clk output latency.
3. PRESCALE=1, FADE_PERIODS=1; settled at 0, then light=24'h000003.
   - Required: duty_b reads 1, 2, 3 on three successive wraps.
   - led_b high 1, 2, 3 cycles in the respective periods.
   - busy stays 1 from the first sampling wrap until duty_b reaches 3, then 0.
4. Change light from 24'h0000FF to 24'h000010 at pwm_cnt=100.
   - Required: the current period keeps 255 high cycles on led_b.
   - The new duty of 16 takes effect only in the period after the wrap.
5. Drop enable at pwm_cnt=50 for 20 cycles, then raise it.
   - Required: leds and frame are 0 from the next edge.
   - pwm_cnt restarts at 0 and the next frame comes 255*PRESCALE cycles after re-enable.
   - Duty is retained.
6. Assert rst for 1 cycle mid-fade (FADE_PERIODS=2, duty_r=40, target=200).
   - Required: all outputs, busy and duty are 0 on the next edge.
   - The next period is dark, then the fade resumes from 0.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver for the 24-bit light word.
// Duty registers only change at PWM period boundaries, optionally ramping by one step every FADE_PERIODS periods.
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned FADE_PERIODS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        frame,
    output logic        busy
);
    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam logic [7:0]  FADE_LAST = 8'(FADE_PERIODS - 1);
    localparam logic [7:0]  PWM_LAST  = 8'd254;

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  fade_cnt_q, fade_cnt_d;
    logic [23:0] target_q, target_d;
    logic        frame_q, frame_d;
    logic        tick, wrap, fade_step;
    logic [2:0]  led_vec, diff_vec;

    always_comb begin
        tick       = enable && (pre_cnt_q == PRE_LAST);
        wrap       = tick && (pwm_cnt_q == PWM_LAST);
        fade_step  = wrap && (FADE_PERIODS != 0) && (fade_cnt_q == FADE_LAST);
        pre_cnt_d  = '0;
        pwm_cnt_d  = '0;
        fade_cnt_d = '0;
        if (enable) begin
            pre_cnt_d  = tick ? '0 : pre_cnt_q + 16'd1;
            pwm_cnt_d  = wrap ? '0 : (tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q);
            fade_cnt_d = fade_cnt_q;
            if (wrap && (FADE_PERIODS != 0)) begin
                fade_cnt_d = fade_step ? '0 : fade_cnt_q + 8'd1;
            end
        end
        // The colour is only ever sampled on the wrap cycle.
        target_d = wrap ? light : target_q;
        frame_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            target_q   <= '0;
            frame_q    <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            target_q   <= target_d;
            frame_q    <= frame_d;
        end
    end

    // Channel gi uses light[8*gi +: 8]: 0 = blue, 1 = green, 2 = red.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [7:0] duty_q, duty_d;
        logic       led_q, led_d;
        logic [7:0] req;

        assign req = light[8*gi +: 8];

        always_comb begin
            duty_d = duty_q;
            if (wrap && (FADE_PERIODS == 0)) begin
                duty_d = req;
            end else if (fade_step) begin
                if (duty_q < req) begin
                    duty_d = duty_q + 8'd1;
                end else if (duty_q > req) begin
                    duty_d = duty_q - 8'd1;
                end
            end
            // pwm_cnt never exceeds 254, so duty 255 holds the pin high all period.
            led_d = enable && (pwm_cnt_q < duty_q);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_q <= '0;
                led_q  <= 1'b0;
            end else begin
                duty_q <= duty_d;
                led_q  <= led_d;
            end
        end

        assign led_vec[gi]  = led_q;
        assign diff_vec[gi] = (duty_q != target_q[8*gi +: 8]);
    end

    assign led_r = led_vec[2];
    assign led_g = led_vec[1];
    assign led_b = led_vec[0];
    assign frame = frame_q;
    assign busy  = |diff_vec;
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: four instances with different PRESCALE/FADE_PERIODS,
// each exercised by its own scenario tasks with hand-computed expectations.
module tb_rgb_pwm_driver;
    logic        clk = 1'b0;
    logic        rst_w   [4];
    logic        en_w    [4];
    logic [23:0] light_w [4];
    logic        led_r_w [4];
    logic        led_g_w [4];
    logic        led_b_w [4];
    logic        frame_w [4];
    logic        busy_w  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1), .FADE_PERIODS(0)) u0 (
        .clk(clk), .rst(rst_w[0]), .enable(en_w[0]), .light(light_w[0]),
        .led_r(led_r_w[0]), .led_g(led_g_w[0]), .led_b(led_b_w[0]),
        .frame(frame_w[0]), .busy(busy_w[0]));
    rgb_pwm_driver #(.PRESCALE(2), .FADE_PERIODS(0)) u1 (
        .clk(clk), .rst(rst_w[1]), .enable(en_w[1]), .light(light_w[1]),
        .led_r(led_r_w[1]), .led_g(led_g_w[1]), .led_b(led_b_w[1]),
        .frame(frame_w[1]), .busy(busy_w[1]));
    rgb_pwm_driver #(.PRESCALE(1), .FADE_PERIODS(1)) u2 (
        .clk(clk), .rst(rst_w[2]), .enable(en_w[2]), .light(light_w[2]),
        .led_r(led_r_w[2]), .led_g(led_g_w[2]), .led_b(led_b_w[2]),
        .frame(frame_w[2]), .busy(busy_w[2]));
    rgb_pwm_driver #(.PRESCALE(1), .FADE_PERIODS(2)) u3 (
        .clk(clk), .rst(rst_w[3]), .enable(en_w[3]), .light(light_w[3]),
        .led_r(led_r_w[3]), .led_g(led_g_w[3]), .led_b(led_b_w[3]),
        .frame(frame_w[3]), .busy(busy_w[3]));

    // Waits (bounded) for the next frame pulse; reports cycles waited.
    task automatic wait_frame(input int i, input int budget, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (frame_w[i]) begin
                ok = 1'b1;
                waited = c;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL frame_timeout inst%0d: no frame within %0d cycles, required one", i, budget);
            n_fail++;
        end
    endtask

    // Samples n cycles after a frame; the last sample is where the next frame is due.
    task automatic count_win(input int i, input int n, output int hr, output int hg, output int hb,
                             output bit shape_ok, output int nframes, output int nbusy,
                             output bit last_frame, output bit last_busy);
        bit pr, pg, pb;
        hr = 0; hg = 0; hb = 0; nframes = 0; nbusy = 0;
        shape_ok = 1'b1; last_frame = 1'b0; last_busy = 1'b0;
        pr = 1'b1; pg = 1'b1; pb = 1'b1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j < n) begin
                nframes += int'(frame_w[i]);
                nbusy   += int'(busy_w[i]);
            end else begin
                last_frame = frame_w[i];
                last_busy  = busy_w[i];
            end
            hr += int'(led_r_w[i]);
            hg += int'(led_g_w[i]);
            hb += int'(led_b_w[i]);
            if ((led_r_w[i] && !pr) || (led_g_w[i] && !pg) || (led_b_w[i] && !pb)) shape_ok = 1'b0;
            pr = led_r_w[i]; pg = led_g_w[i]; pb = led_b_w[i];
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            rst_w[i] = 1'b1; en_w[i] = 1'b1; light_w[i] = 24'hFFFFFF;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({led_r_w[i], led_g_w[i], led_b_w[i], frame_w[i], busy_w[i]} !== 5'b0) begin
                $display("FAIL reset_outputs inst%0d: got %b, required 00000", i,
                         {led_r_w[i], led_g_w[i], led_b_w[i], frame_w[i], busy_w[i]});
                n_fail++;
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_first_period_red;
        int dark_bad, frame_bad, red_bad;
        dark_bad = 0; frame_bad = 0; red_bad = 0;
        rst_w[0] = 1'b0; en_w[0] = 1'b1; light_w[0] = 24'hFF0000;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (frame_w[0] !== ((k == 255) || (k == 510) || (k == 765))) frame_bad++;
            if (k <= 255) begin
                if (led_r_w[0] || led_g_w[0] || led_b_w[0]) dark_bad++;
            end else if ({led_r_w[0], led_g_w[0], led_b_w[0]} !== 3'b100) begin
                red_bad++;
            end
        end
        n_checks++;
        if (dark_bad !== 0) begin
            $display("FAIL first_period_dark: %0d lit cycles, required 0", dark_bad); n_fail++;
        end
        n_checks++;
        if (frame_bad !== 0) begin
            $display("FAIL frame_every_255: %0d wrong frame cycles, required 0", frame_bad); n_fail++;
        end
        n_checks++;
        if (red_bad !== 0) begin
            $display("FAIL red_constant: %0d wrong led cycles, required 0", red_bad); n_fail++;
        end
        $display("test_first_period_red: dark_bad=%0d frame_bad=%0d red_bad=%0d", dark_bad, frame_bad, red_bad);
    endtask

    task automatic test_duty_prescale2;
        int w, hr, hg, hb, nf, nb;
        bit shape, lf, lb;
        rst_w[1] = 1'b0; en_w[1] = 1'b1; light_w[1] = 24'h804000;
        wait_frame(1, 600, w);
        n_checks++;
        if (w !== 510) begin
            $display("FAIL first_frame_p2: at cycle %0d, required 510", w); n_fail++;
        end
        wait_frame(1, 600, w);
        n_checks++;
        if (w !== 510) begin
            $display("FAIL period_p2: %0d cycles, required 510", w); n_fail++;
        end
        count_win(1, 510, hr, hg, hb, shape, nf, nb, lf, lb);
        n_checks++;
        if (hr !== 256 || hg !== 128 || hb !== 0) begin
            $display("FAIL duty_p2: r/g/b high %0d/%0d/%0d, required 256/128/0", hr, hg, hb); n_fail++;
        end
        n_checks++;
        if (!shape || nf !== 0 || !lf) begin
            $display("FAIL shape_p2: contiguous=%0d inner_frames=%0d end_frame=%0d, required 1/0/1", shape, nf, lf);
            n_fail++;
        end
        $display("test_duty_prescale2: r=%0d g=%0d b=%0d", hr, hg, hb);
    endtask

    task automatic test_fade_up;
        int w, hr, hg, hb, nf, nb;
        bit shape, lf, lb;
        int exp_hb [3]  = '{1, 2, 3};
        int exp_nb [3]  = '{254, 254, 0};
        bit exp_lb [3]  = '{1'b1, 1'b0, 1'b0};
        rst_w[2] = 1'b0; en_w[2] = 1'b1; light_w[2] = 24'h000000;
        wait_frame(2, 300, w);
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy_w[2] !== 1'b0) begin
            $display("FAIL fade_settled_busy: got %b, required 0", busy_w[2]); n_fail++;
        end
        light_w[2] = 24'h000003;
        wait_frame(2, 300, w);
        n_checks++;
        if (busy_w[2] !== 1'b1) begin
            $display("FAIL fade_busy_start: got %b, required 1", busy_w[2]); n_fail++;
        end
        for (int p = 0; p < 3; p++) begin
            count_win(2, 255, hr, hg, hb, shape, nf, nb, lf, lb);
            n_checks++;
            if (hb !== exp_hb[p] || hr !== 0 || hg !== 0 || !shape) begin
                $display("FAIL fade_step%0d: b/r/g high %0d/%0d/%0d shape=%0d, required %0d/0/0 shape=1",
                         p + 1, hb, hr, hg, shape, exp_hb[p]);
                n_fail++;
            end
            n_checks++;
            if (nb !== exp_nb[p] || lb !== exp_lb[p] || !lf) begin
                $display("FAIL fade_busy%0d: busy cycles=%0d end_busy=%0d end_frame=%0d, required %0d/%0d/1",
                         p + 1, nb, lb, lf, exp_nb[p], exp_lb[p]);
                n_fail++;
            end
            $display("test_fade_up: period %0d blue high %0d busy cycles %0d", p + 1, hb, nb);
        end
    endtask

    task automatic test_midperiod_change;
        int w, hr, hb, hg, nf, nb;
        bit shape, lf, lb;
        light_w[0] = 24'h0000FF;
        wait_frame(0, 300, w);
        hr = 0; hb = 0; lf = 1'b0;
        for (int j = 1; j <= 255; j++) begin
            @(negedge clk);
            hr += int'(led_r_w[0]);
            hb += int'(led_b_w[0]);
            if (j == 100) light_w[0] = 24'h000010;
            if (j == 255) lf = frame_w[0];
        end
        n_checks++;
        if (hb !== 255 || hr !== 0 || !lf) begin
            $display("FAIL change_current_period: b/r high %0d/%0d end_frame=%0d, required 255/0/1", hb, hr, lf);
            n_fail++;
        end
        count_win(0, 255, hr, hg, hb, shape, nf, nb, lf, lb);
        n_checks++;
        if (hb !== 16 || hr !== 0 || hg !== 0 || !shape || nb !== 0) begin
            $display("FAIL change_next_period: b/r/g high %0d/%0d/%0d shape=%0d busy=%0d, required 16/0/0 shape=1 busy=0",
                     hb, hr, hg, shape, nb);
            n_fail++;
        end
        $display("test_midperiod_change: next period blue high %0d", hb);
    endtask

    task automatic test_enable_drop;
        int hr, hg, hb, nf, nb, lit;
        bit shape, lf, lb;
        // Instance 1 sits at a frame sample here (end of the previous window).
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (j == 100) en_w[1] = 1'b0;
        end
        lit = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            lit += int'(led_r_w[1]) + int'(led_g_w[1]) + int'(led_b_w[1]) + int'(frame_w[1]);
            if (j == 20) en_w[1] = 1'b1;
        end
        n_checks++;
        if (lit !== 0) begin
            $display("FAIL disabled_outputs: %0d high samples, required 0", lit); n_fail++;
        end
        count_win(1, 510, hr, hg, hb, shape, nf, nb, lf, lb);
        n_checks++;
        if (nf !== 0 || !lf) begin
            $display("FAIL reenable_frame: inner_frames=%0d end_frame=%0d, required 0/1", nf, lf); n_fail++;
        end
        n_checks++;
        if (hr !== 256 || hg !== 128 || hb !== 0 || !shape) begin
            $display("FAIL reenable_duty: r/g/b high %0d/%0d/%0d shape=%0d, required 256/128/0 shape=1",
                     hr, hg, hb, shape);
            n_fail++;
        end
        $display("test_enable_drop: lit=%0d r=%0d g=%0d", lit, hr, hg);
    endtask

    task automatic test_reset_mid_fade;
        int w, hr, hg, hb, nf, nb, nbusy;
        bit shape, lf, lb;
        int exp_hr [3] = '{0, 0, 1};
        int exp_nb [3] = '{0, 254, 254};
        rst_w[3] = 1'b0; en_w[3] = 1'b1; light_w[3] = 24'hC80000;
        for (int f = 0; f < 80; f++) wait_frame(3, 300, w);
        hr = 0; nbusy = 0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            hr += int'(led_r_w[3]);
            nbusy += int'(busy_w[3]);
            if (j == 100) rst_w[3] = 1'b1;
        end
        n_checks++;
        if (hr !== 40 || nbusy !== 100) begin
            $display("FAIL prefade_duty: red high %0d busy %0d, required 40/100", hr, nbusy); n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if ({led_r_w[3], led_g_w[3], led_b_w[3], frame_w[3], busy_w[3]} !== 5'b0) begin
            $display("FAIL midfade_reset: got %b, required 00000",
                     {led_r_w[3], led_g_w[3], led_b_w[3], frame_w[3], busy_w[3]});
            n_fail++;
        end
        rst_w[3] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            count_win(3, 255, hr, hg, hb, shape, nf, nb, lf, lb);
            n_checks++;
            if (hr !== exp_hr[p] || nb !== exp_nb[p] || !lf || !lb || nf !== 0) begin
                $display("FAIL refade%0d: red=%0d busy=%0d frame=%0d end_busy=%0d, required %0d/%0d/1/1",
                         p + 1, hr, nb, lf, lb, exp_hr[p], exp_nb[p]);
                n_fail++;
            end
            $display("test_reset_mid_fade: period %0d red high %0d", p + 1, hr);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_w[i] = 1'b1; en_w[i] = 1'b0; light_w[i] = 24'h0;
        end
        test_reset();
        test_first_period_red();
        test_duty_prescale2();
        test_enable_drop();
        test_fade_up();
        test_midperiod_change();
        test_reset_mid_fade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
